// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multicycle controller.
//   - opcode / func encodings of the 16-bit ISA
//   - FSM state encoding (also exported on the debug `state` port)
//   - ALU operation, ALU B-source, PC-source and trap-cause codes
//   - instruction class enum and the control word latched in DECODE
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_RWB    = 3'd3,
        S_MEM    = 3'd4,
        S_LWB    = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    localparam logic [3:0] OP_SHIFT = 4'b0000;
    localparam logic [3:0] OP_LW    = 4'b0001;
    localparam logic [3:0] OP_SW    = 4'b0010;
    localparam logic [3:0] OP_JMP   = 4'b0011;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BNE   = 4'b0101;
    localparam logic [3:0] OP_ORI   = 4'b0110;
    localparam logic [3:0] OP_NANDI = 4'b0111;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_ADDI1 = 4'b1001;
    localparam logic [3:0] OP_ADDI2 = 4'b1010;
    localparam logic [3:0] OP_NAND  = 4'b1011;
    localparam logic [3:0] OP_SUB   = 4'b1100;
    localparam logic [3:0] OP_SUBI1 = 4'b1101;
    localparam logic [3:0] OP_SUBI2 = 4'b1110;
    localparam logic [3:0] OP_OR    = 4'b1111;

    localparam logic [3:0] FN_SLL = 4'd1;
    localparam logic [3:0] FN_SRL = 4'd2;
    localparam logic [3:0] FN_SRA = 4'd3;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_NAND = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_SRA  = 3'b111;

    localparam logic [2:0] SRCB_REG  = 3'b000;
    localparam logic [2:0] SRCB_ONE  = 3'b001;
    localparam logic [2:0] SRCB_IMM  = 3'b010;
    localparam logic [2:0] SRCB_MOFF = 3'b011;
    localparam logic [2:0] SRCB_JT   = 3'b100;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_JMP  = 2'b01;
    localparam logic [1:0] PCSRC_TRAP = 2'b10;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TMO     = 2'b10;

    typedef enum logic [2:0] {
        CL_NONE   = 3'd0,
        CL_ALU_R  = 3'd1,   // register-register ALU op
        CL_ALU_I  = 3'd2,   // immediate ALU op or shift
        CL_BRANCH = 3'd3,
        CL_JMP    = 3'd4,
        CL_LOAD   = 3'd5,
        CL_STORE  = 3'd6
    } class_t;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       sign_ext;
        logic       br_ne;     // branch flavour: 1 = BNE, 0 = BEQ
    } ctrl_word_t;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: combinational opcode/func decoder.
//   opcode, func : raw instruction fields (only the low 4 bits carry meaning)
//   cls          : instruction class
//   cw           : ALU op / sign-extend / branch flavour
//   illegal      : undefined encoding (nonzero upper bits, or bad shift func)
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OP_W   = 4,
    parameter int FUNC_W = 4
) (
    input  logic [OP_W-1:0]   opcode,
    input  logic [FUNC_W-1:0] func,
    output class_t            cls,
    output ctrl_word_t        cw,
    output logic              illegal
);

    logic [3:0] op4;
    logic [3:0] fn4;
    logic       hi_bad;

    assign op4    = opcode[3:0];
    assign fn4    = func[3:0];
    // Widened fields must keep their upper bits clear to stay legal.
    assign hi_bad = ((opcode >> 4) != '0) || ((func >> 4) != '0);

    always_comb begin
        cls     = CL_NONE;
        cw      = '0;
        illegal = hi_bad;
        case (op4)
            OP_ADD:   begin cls = CL_ALU_R; cw.alu_op = ALU_ADD; end
            OP_ADDI1: begin cls = CL_ALU_I; cw.alu_op = ALU_ADD; cw.sign_ext = 1'b1; end
            OP_ADDI2: begin cls = CL_ALU_I; cw.alu_op = ALU_ADD; end
            OP_SUB:   begin cls = CL_ALU_R; cw.alu_op = ALU_SUB; end
            OP_SUBI1: begin cls = CL_ALU_I; cw.alu_op = ALU_SUB; cw.sign_ext = 1'b1; end
            OP_SUBI2: begin cls = CL_ALU_I; cw.alu_op = ALU_SUB; end
            OP_NAND:  begin cls = CL_ALU_R; cw.alu_op = ALU_NAND; end
            OP_NANDI: begin cls = CL_ALU_I; cw.alu_op = ALU_NAND; end
            OP_OR:    begin cls = CL_ALU_R; cw.alu_op = ALU_OR; end
            OP_ORI:   begin cls = CL_ALU_I; cw.alu_op = ALU_OR; cw.sign_ext = 1'b1; end
            OP_BEQ:   begin cls = CL_BRANCH; cw.alu_op = ALU_SUB; end
            OP_BNE:   begin cls = CL_BRANCH; cw.alu_op = ALU_SUB; cw.br_ne = 1'b1; end
            OP_JMP:   cls = CL_JMP;
            OP_LW:    begin cls = CL_LOAD;  cw.alu_op = ALU_ADD; cw.sign_ext = 1'b1; end
            OP_SW:    begin cls = CL_STORE; cw.alu_op = ALU_ADD; cw.sign_ext = 1'b1; end
            OP_SHIFT: begin
                cls = CL_ALU_I;
                case (fn4)
                    FN_SLL:  cw.alu_op = ALU_SLL;
                    FN_SRL:  cw.alu_op = ALU_SRL;
                    FN_SRA:  cw.alu_op = ALU_SRA;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control FSM (FETCH/DECODE/EXEC/RWB/MEM/LWB/TRAP).
//   clk, rst        : clock, synchronous active-high reset
//   opcode, func    : instruction fields, sampled only in DECODE
//   mem_ready       : memory completion, sampled only in FETCH and MEM
//   pc_write .. br_ne, pc_src, alu_op, alu_src_a/b, sign_ext, read_r*_sel,
//   reg_dst, mem_to_reg : datapath strobes and selects
//   trap, trap_cause : one-cycle trap pulse and its reason
//   state           : current state, for debug
// Optional feature macro CTRL_TIMEOUT_EN: traps (cause 10) after TMO_CYC
// consecutive wait cycles in FETCH or MEM. Without it the FSM waits forever.
module mc_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int OP_W    = 4,
    parameter int FUNC_W  = 4,
    parameter int TMO_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [OP_W-1:0]   opcode,
    input  logic [FUNC_W-1:0] func,
    input  logic              mem_ready,
    output logic              pc_write,
    output logic              ir_write,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              br_eq,
    output logic              br_ne,
    output logic [1:0]        pc_src,
    output logic [2:0]        alu_op,
    output logic              alu_src_a,
    output logic [2:0]        alu_src_b,
    output logic              sign_ext,
    output logic              read_r2_sel,
    output logic              reg_dst,
    output logic              mem_to_reg,
    output logic [1:0]        read_r1_sel,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [2:0]        state
);

    state_t     state_q, state_d;
    class_t     cls_q, d_cls;
    ctrl_word_t cw_q, d_cw;
    logic       d_illegal;
    logic [1:0] cause_q, cause_d;
    logic       tmo_hit;

    ctrl_decode #(.OP_W(OP_W), .FUNC_W(FUNC_W)) u_decode (
        .opcode  (opcode),
        .func    (func),
        .cls     (d_cls),
        .cw      (d_cw),
        .illegal (d_illegal)
    );

`ifdef CTRL_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TMO_CYC) > 4) ? $clog2(TMO_CYC) : 4;
    logic [TMO_W-1:0] tmo_cnt;

    // tmo_cnt holds the number of earlier consecutive wait cycles, so the
    // TMO_CYC-th waiting cycle is the one that diverts to TRAP.
    assign tmo_hit = !mem_ready && (tmo_cnt == TMO_W'(TMO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst)
            tmo_cnt <= '0;
        else if (mem_ready || state_d != state_q ||
                 !(state_q == S_FETCH || state_q == S_MEM))
            tmo_cnt <= '0;
        else
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    logic unused_tmo;
    assign unused_tmo = ^TMO_CYC;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= CL_NONE;
            cw_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= d_cls;
                cw_q  <= d_cw;
            end
            if (state_d == S_TRAP)
                cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cause_d     = CAUSE_ILLEGAL;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        br_eq       = 1'b0;
        br_ne       = 1'b0;
        pc_src      = PCSRC_ALU;
        alu_op      = ALU_ADD;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REG;
        sign_ext    = 1'b0;
        read_r2_sel = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        read_r1_sel = 2'b00;
        trap        = 1'b0;
        trap_cause  = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_ONE;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TMO;
                end
            end
            S_DECODE: state_d = d_illegal ? S_TRAP : S_EXEC;
            S_EXEC: begin
                alu_op   = cw_q.alu_op;
                sign_ext = cw_q.sign_ext;
                state_d  = S_FETCH;
                case (cls_q)
                    CL_ALU_R: begin
                        alu_src_a = 1'b1;
                        state_d   = S_RWB;
                    end
                    CL_ALU_I: begin
                        alu_src_b   = SRCB_IMM;
                        read_r1_sel = 2'b01;
                        state_d     = S_RWB;
                    end
                    CL_BRANCH: begin
                        br_eq = !cw_q.br_ne;
                        br_ne = cw_q.br_ne;
                    end
                    CL_JMP: begin
                        pc_src    = PCSRC_JMP;
                        alu_src_b = SRCB_JT;
                        pc_write  = 1'b1;
                    end
                    CL_LOAD, CL_STORE: begin
                        alu_src_b   = SRCB_MOFF;
                        read_r1_sel = 2'b10;
                        read_r2_sel = 1'b1;
                        state_d     = S_MEM;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM: begin
                mem_read  = (cls_q == CL_LOAD);
                mem_write = (cls_q == CL_STORE);
                if (mem_ready) begin
                    state_d = (cls_q == CL_LOAD) ? S_LWB : S_FETCH;
                end else if (tmo_hit) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TMO;
                end
            end
            S_LWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                trap       = 1'b1;
                pc_src     = PCSRC_TRAP;
                pc_write   = 1'b1;
                trap_cause = cause_q;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign state = state_q;

endmodule
